// File: rtl/adjust_ctrl.sv
// adjust_ctrl: closed-loop phase-offset controller driving the 8-bit param word.
// Latency: sig->accumulator 3 cycles; win_valid one cycle after the last window
//          sample; param updates one cycle later (EVAL).
// Backpressure: none; free-running measurement loop gated only by en.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   sig        comparator feedback (asynchronous, synchronised internally)
//   en         loop enable, level-sensitive; low returns to IDLE
//   level      requested output level, registered into param[7]
//   param      {pol-adjusted level, offset[6:0]}
//   win_count  high-count of the last completed window
//   win_valid  one-cycle pulse when win_count updates
//   locked     LOCK_WIN consecutive in-band windows seen
//   sat        offset pinned at a rail while the error persists
//
// Optional feature macro: ADJUST_CTRL_POLFLIP_EN (polarity flip on saturation).
module adjust_ctrl #(
  parameter int WINDOW_BITS = 11,
  parameter int TARGET      = 1024,
  parameter int HYST        = 32,
  parameter int SETTLE_WIN  = 1,
  parameter int LOCK_WIN    = 4,
  parameter int INIT_OFFSET = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig,
  input  logic                 en,
  input  logic                 level,
  output logic [7:0]           param,
  output logic [WINDOW_BITS:0] win_count,
  output logic                 win_valid,
  output logic                 locked,
  output logic                 sat
);

  localparam int CW = WINDOW_BITS + 1;   // accumulator holds the full 2^WINDOW_BITS
  localparam int EW = WINDOW_BITS + 2;   // signed error width
  localparam int LW = $clog2(LOCK_WIN + 1);
  localparam int SW = (SETTLE_WIN > 1) ? $clog2(SETTLE_WIN) : 1;
  localparam int SETTLE_LAST_I = (SETTLE_WIN > 0) ? SETTLE_WIN - 1 : 0;

  localparam logic [WINDOW_BITS-1:0] WIN_LAST    = '1;
  localparam logic [6:0]             INIT_OFS    = 7'(INIT_OFFSET);
  localparam logic [6:0]             OFS_MAX     = 7'h7f;
  localparam logic [6:0]             OFS_MIN     = 7'h00;
  localparam logic signed [EW-1:0]   TGT         = EW'(TARGET);
  localparam logic signed [EW-1:0]   HY_POS      = EW'(HYST);
  localparam logic signed [EW-1:0]   HY_NEG      = -EW'(HYST);
  localparam logic [LW-1:0]          LOCK_CNT    = LW'(LOCK_WIN);
  localparam logic [SW-1:0]          SETTLE_LAST = SW'(SETTLE_LAST_I);

  typedef enum logic [1:0] {IDLE, MEASURE, EVAL, SETTLE} state_t;

  state_t state, state_nxt;

  logic                   sync1, sync2;
  logic [WINDOW_BITS-1:0] wcnt;
  logic [CW-1:0]          acc;
  logic [CW-1:0]          acc_sum;
  logic [6:0]             offset;
  logic                   pol;
  logic                   p7;
  logic [LW-1:0]          band_cnt;
  logic [SW-1:0]          settle_cnt;

  logic                   win_end;
  logic signed [EW-1:0]   err;
  logic                   err_hi, err_lo;

  logic [6:0]             ofs_nxt;
  logic                   pol_nxt;
  logic                   sat_nxt;
  logic                   lock_nxt;
  logic [LW-1:0]          band_nxt;
  logic                   step_chg;

  assign win_end = (wcnt == WIN_LAST);
  assign acc_sum = acc + CW'(sync2);
  // Zero-extend the unsigned count by one bit so the subtraction is signed-safe.
  assign err     = $signed({1'b0, win_count}) - TGT;
  assign err_hi  = (err > HY_POS);
  assign err_lo  = (err < HY_NEG);

  assign param   = {p7, offset};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. en low wins everywhere, so a window ending on the same
  // edge that en is seen low is dropped without a win_valid.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (!en)          state_nxt = IDLE;
        else if (win_end) state_nxt = EVAL;
      end
      EVAL: begin
        if (!en)                             state_nxt = IDLE;
        else if (step_chg && SETTLE_WIN > 0) state_nxt = SETTLE;
        else                                 state_nxt = MEASURE;
      end
      SETTLE: begin
        if (!en)                                          state_nxt = IDLE;
        else if (win_end && settle_cnt == SETTLE_LAST)    state_nxt = MEASURE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs: offset / polarity / lock / saturation decisions.
  always_comb begin
    ofs_nxt  = offset;
    pol_nxt  = pol;
    sat_nxt  = sat;
    lock_nxt = locked;
    band_nxt = band_cnt;
    case (state)
      IDLE: begin
        if (en) begin
          ofs_nxt = INIT_OFS;
          pol_nxt = 1'b0;
        end
      end
      EVAL: begin
        if (en) begin
          if (err_hi) begin
            band_nxt = '0;
            lock_nxt = 1'b0;
            if (offset == OFS_MAX) begin
              sat_nxt = 1'b1;
`ifdef ADJUST_CTRL_POLFLIP_EN
              // Out of range at the top rail: invert drive and restart mid-scale.
              pol_nxt = ~pol;
              ofs_nxt = INIT_OFS;
`endif
            end else begin
              ofs_nxt = offset + 7'd1;
              sat_nxt = 1'b0;
            end
          end else if (err_lo) begin
            band_nxt = '0;
            lock_nxt = 1'b0;
            if (offset == OFS_MIN) begin
              sat_nxt = 1'b1;
`ifdef ADJUST_CTRL_POLFLIP_EN
              pol_nxt = ~pol;
              ofs_nxt = INIT_OFS;
`endif
            end else begin
              ofs_nxt = offset - 7'd1;
              sat_nxt = 1'b0;
            end
          end else begin
            sat_nxt = 1'b0;
            if (band_cnt < LOCK_CNT) band_nxt = band_cnt + 1'b1;
            lock_nxt = (band_nxt == LOCK_CNT);
          end
        end
      end
      default: ;
    endcase
  end

  // A settle window is needed whenever the adjust stage sees a new word.
  assign step_chg = (ofs_nxt != offset) || (pol_nxt != pol);

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      wcnt       <= '0;
      acc        <= '0;
      win_count  <= '0;
      win_valid  <= 1'b0;
      offset     <= INIT_OFS;
      pol        <= 1'b0;
      p7         <= 1'b0;
      band_cnt   <= '0;
      locked     <= 1'b0;
      sat        <= 1'b0;
      settle_cnt <= '0;
    end else begin
      sync1     <= sig;
      sync2     <= sync1;
      win_valid <= 1'b0;
      offset    <= ofs_nxt;
      pol       <= pol_nxt;
      // Uses the next polarity so a flip and its new offset reach the stage together.
      p7        <= level ^ pol_nxt;
      if (!en) begin
        wcnt       <= '0;
        acc        <= '0;
        band_cnt   <= '0;
        locked     <= 1'b0;
        sat        <= 1'b0;
        settle_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            wcnt       <= '0;
            acc        <= '0;
            settle_cnt <= '0;
          end
          MEASURE: begin
            wcnt <= wcnt + 1'b1;
            if (win_end) begin
              win_count <= acc_sum;
              win_valid <= 1'b1;
              acc       <= '0;
            end else begin
              acc <= acc_sum;
            end
          end
          EVAL: begin
            sat        <= sat_nxt;
            locked     <= lock_nxt;
            band_cnt   <= band_nxt;
            settle_cnt <= '0;
          end
          SETTLE: begin
            // Full-length discarded windows; wcnt wraps to 0 on its own.
            wcnt <= wcnt + 1'b1;
            if (win_end) settle_cnt <= settle_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adjust_ctrl.sv
// tb_adjust_ctrl: table-driven, hand-sequenced and randomized checks of adjust_ctrl.
// A second instance with a low initial offset reaches the lower rail quickly.
module tb_adjust_ctrl;

  logic        clk;
  logic        rst, sig, en, level;
  logic [7:0]  param;
  logic [11:0] win_count;
  logic        win_valid, locked, sat;

  logic        rst_b, sig_b, en_b, level_b;
  logic [7:0]  param_b;
  logic [11:0] win_count_b;
  logic        win_valid_b, locked_b, sat_b;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int wv_seen = 0;
  bit hist [0:131071];

  bit       sq_mode = 0;
  bit       rnd_mode = 0;
  int       thr = 500;
  logic [1:0] sq_ph = 2'd0;

  typedef struct {
    int n;
    int delta;
    bit lock;
  } vec_t;

  adjust_ctrl u_dut (
    .clk(clk), .rst(rst), .sig(sig), .en(en), .level(level),
    .param(param), .win_count(win_count), .win_valid(win_valid),
    .locked(locked), .sat(sat)
  );

  adjust_ctrl #(.INIT_OFFSET(1)) u_rail (
    .clk(clk), .rst(rst_b), .sig(sig_b), .en(en_b), .level(level_b),
    .param(param_b), .win_count(win_count_b), .win_valid(win_valid_b),
    .locked(locked_b), .sat(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    hist[cyc] <= sig;
    cyc <= cyc + 1;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: sim time %0t, required finish before 1500000", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic go_edge();
    @(posedge clk);
    #1;
    if (sq_mode) begin
      sq_ph = sq_ph + 2'd1;
      sig = sq_ph[1];
    end else if (rnd_mode) begin
      sig = ($urandom_range(0, 999) < thr);
    end
    if (win_valid) wv_seen++;
  endtask

  task automatic wait_wv();
    bit ok = 0;
    for (int i = 0; i < 4200; i++) begin
      go_edge();
      if (win_valid) begin
        ok = 1;
        break;
      end
    end
    chk("wv_timeout", 32'(ok), 1);
  endtask

  task automatic wait_wv_b();
    bit ok = 0;
    for (int i = 0; i < 4200; i++) begin
      @(posedge clk);
      #1;
      if (win_valid_b) begin
        ok = 1;
        break;
      end
    end
    chk("b_wv_timeout", 32'(ok), 1);
  endtask

  // Sum of the 2048 sig samples that feed the window reported on edge e
  // (3-register path from sig to the accumulator).
  function automatic int wsum(input int e);
    int s = 0;
    for (int i = e - 2049; i <= e - 2; i++) s += int'(hist[i]);
    return s;
  endfunction

  task automatic run_main();
    int c0, e, n, last_e, ofs, seen0;
    bit settle;
    int m_ofs, m_band, err;
    bit m_lock, m_sat;
    vec_t tbl [10];
    tbl[0] = '{1024,  0, 0};
    tbl[1] = '{1056,  0, 0};
    tbl[2] = '{1057,  1, 0};
    tbl[3] = '{ 992,  0, 0};
    tbl[4] = '{ 991, -1, 0};
    tbl[5] = '{1040,  0, 0};
    tbl[6] = '{1000,  0, 0};
    tbl[7] = '{1024,  0, 0};
    tbl[8] = '{1030,  0, 1};
    tbl[9] = '{1500,  1, 0};

    repeat (3) go_edge();
    chk("rst_param", 32'(param), 'h40);
    chk("rst_win_count", 32'(win_count), 0);
    chk("rst_win_valid", 32'(win_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sat", 32'(sat), 0);

    rst = 1; sig = 1;
    repeat (4) go_edge();
    chk("idle_param", 32'(param), 'h40);
    chk("idle_no_wv", 32'(wv_seen), 0);

    level = 1;
    chk("level_hold", 32'(param[7]), 0);
    go_edge();
    chk("level_follow", 32'(param[7]), 1);
    level = 0;
    go_edge();
    chk("level_back", 32'(param[7]), 0);

    // sig held high: every window is full scale and steps the offset up.
    c0 = cyc; en = 1;
    for (int k = 0; k < 3; k++) begin
      wait_wv();
      e = cyc - 1;
      if (k == 0) chk("first_latency", cyc - c0, 2049);
      else        chk("ones_spacing", e - last_e, 4097);
      last_e = e;
      chk("ones_count", 32'(win_count), 2048);
      go_edge();
      chk("ones_param", 32'(param), 'h41 + k);
      chk("ones_locked", 32'(locked), 0);
      chk("ones_sat", 32'(sat), 0);
    end

    // Exact high-counts around the band edges.
    sig = 0; ofs = 67; settle = 1;
    for (int i = 0; i < 10; i++) begin
      if (settle) repeat (2047) go_edge();
      sig = 1;
      repeat (tbl[i].n) go_edge();
      sig = 0;
      wait_wv();
      e = cyc - 1;
      chk("tbl_spacing", e - last_e, settle ? 4097 : 2049);
      last_e = e;
      chk("tbl_count", 32'(win_count), tbl[i].n);
      go_edge();
      ofs += tbl[i].delta;
      chk("tbl_param", 32'(param), ofs);
      chk("tbl_locked", 32'(locked), 32'(tbl[i].lock));
      chk("tbl_sat", 32'(sat), 0);
      settle = (tbl[i].delta != 0);
    end

    // en dropped in the middle of a SETTLE window, re-raised 10 cycles later.
    repeat (500) go_edge();
    seen0 = wv_seen;
    en = 0;
    go_edge();
    chk("drop_locked", 32'(locked), 0);
    chk("drop_sat", 32'(sat), 0);
    chk("drop_param_hold", 32'(param), 'h44);
    sq_mode = 1;
    repeat (10) go_edge();
    chk("drop_no_wv", wv_seen - seen0, 0);
    c0 = cyc; en = 1;
    go_edge();
    chk("rearm_param", 32'(param), 'h40);

    // 50% square wave: in band every window, lock after four.
    for (int k = 0; k < 4; k++) begin
      wait_wv();
      e = cyc - 1;
      if (k == 0) chk("sq_latency", cyc - c0, 2049);
      else        chk("sq_spacing", e - last_e, 2049);
      last_e = e;
      chk("sq_count", 32'(win_count), 1024);
      go_edge();
      chk("sq_param", 32'(param), 'h40);
      chk("sq_locked", 32'(locked), (k == 3) ? 1 : 0);
    end

    // Randomized density against the behavioural model.
    sq_mode = 0; rnd_mode = 1;
    m_ofs = 64; m_band = 4; m_lock = 1; m_sat = 0; settle = 0; n = 0;
    for (int k = 0; k < 5; k++) begin
      thr = $urandom_range(380, 620);
      wait_wv();
      e = cyc - 1;
      chk("rnd_spacing", e - last_e, settle ? 4097 : 2049);
      last_e = e;
      n = wsum(e);
      chk("rnd_count", 32'(win_count), n);
      err = n - 1024;
      settle = 0;
      if (err > 32) begin
        m_band = 0; m_lock = 0;
        if (m_ofs == 127) m_sat = 1;
        else begin m_ofs++; m_sat = 0; settle = 1; end
      end else if (err < -32) begin
        m_band = 0; m_lock = 0;
        if (m_ofs == 0) m_sat = 1;
        else begin m_ofs--; m_sat = 0; settle = 1; end
      end else begin
        m_sat = 0;
        if (m_band < 4) m_band++;
        m_lock = (m_band >= 4);
      end
      go_edge();
      chk("rnd_param", 32'(param), m_ofs);
      chk("rnd_locked", 32'(locked), 32'(m_lock));
      chk("rnd_sat", 32'(sat), 32'(m_sat));
    end

    // en falls exactly on the last sample edge of a window.
    rnd_mode = 0; sig = 0;
    repeat (settle ? 4095 : 2047) go_edge();
    en = 0;
    seen0 = wv_seen;
    repeat (6) go_edge();
    chk("bnd_no_wv", wv_seen - seen0, 0);
    chk("bnd_count_hold", 32'(win_count), n);
    chk("bnd_param_hold", 32'(param), m_ofs);
    chk("bnd_locked", 32'(locked), 0);

    // Asynchronous reset in the middle of a window.
    level = 1; en = 1;
    repeat (1000) go_edge();
    chk("pre_rst_param", 32'(param), 'hC0);
    #2;
    rst = 0;
    #1;
    chk("arst_param", 32'(param), 'h40);
    chk("arst_win_count", 32'(win_count), 0);
    chk("arst_win_valid", 32'(win_valid), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_sat", 32'(sat), 0);
    level = 0;
    repeat (2) go_edge();
    rst = 1;
    c0 = cyc;
    wait_wv();
    chk("arst_first_latency", cyc - c0, 2049);
  endtask

  // sig stuck low with the offset starting one step above the lower rail.
  task automatic run_rail();
    repeat (3) @(posedge clk);
    #1;
    chk("b_rst_param", 32'(param_b), 'h01);
    rst_b = 1;
    repeat (3) @(posedge clk);
    #1;
    en_b = 1;
    wait_wv_b();
    chk("b_w1_count", 32'(win_count_b), 0);
    @(posedge clk); #1;
    chk("b_w1_param", 32'(param_b), 'h80);
    chk("b_w1_sat", 32'(sat_b), 0);
    wait_wv_b();
    @(posedge clk); #1;
`ifdef ADJUST_CTRL_POLFLIP_EN
    chk("b_w2_param_flip", 32'(param_b), 'h01);
`else
    chk("b_w2_param_pin", 32'(param_b), 'h80);
`endif
    chk("b_w2_sat", 32'(sat_b), 1);
    wait_wv_b();
    @(posedge clk); #1;
`ifdef ADJUST_CTRL_POLFLIP_EN
    chk("b_w3_param", 32'(param_b), 'h00);
    chk("b_w3_sat", 32'(sat_b), 0);
`else
    chk("b_w3_param", 32'(param_b), 'h80);
    chk("b_w3_sat", 32'(sat_b), 1);
`endif
    chk("b_w3_locked", 32'(locked_b), 0);
  endtask

  initial begin
    rst = 0; sig = 0; en = 0; level = 0;
    rst_b = 0; sig_b = 0; en_b = 0; level_b = 1;
    fork
      run_main();
      run_rail();
    join
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
